// File: rtl/uart_pkg.sv
// Shared UART types and constants for the rx/tx word-path receiver and transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;
  localparam int UART_FRAME_BITS = 8;
  localparam int UART_OVERSAMPLE = 16;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad; resets to the idle-high line level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_word.sv
// Oversampling UART receiver packing DATA_WIDTH/8 bytes LSB-byte-first into a valid/ready word.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [SCNT_W-1:0] MID_START = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] BIT_END   = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_FRAME_BITS - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64 ||
      (OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_chk
    $error("uart_rx_word: illegal parameter set");
  end

  logic                  rx_s;
  uart_rx_state_t        state;
  logic [SCNT_W-1:0]     sample;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic [BIDX_W-1:0]     byte_idx;
  logic [DATA_WIDTH-1:0] word_buf;
  logic                  word_done;

  uart_rx_sync u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sample    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      word_done <= 1'b0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      word_done <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Completed words land one clk after the stop sample; a held word is never replaced.
      if (word_done) begin
        if (!valid || ready) begin
          data_out <= word_buf;
          valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (clken) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START;
              sample <= '0;
            end
          end
          START: begin
            if (sample == MID_START) begin
              sample  <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              sample <= sample + SCNT_W'(1);
            end
          end
          DATA: begin
            if (sample == BIT_END) begin
              sample  <= '0;
              shreg   <= {rx_s, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              sample <= sample + SCNT_W'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (sample == BIT_END) begin
              sample  <= '0;
              par_bad <= rx_s != ((^shreg) ^ (PARITY_ODD != 0));
              state   <= STOP;
            end else begin
              sample <= sample + SCNT_W'(1);
            end
          end
`endif
          STOP: begin
            // Leave at mid-stop so a following start edge half a bit later is caught.
            if (sample == BIT_END) begin
              sample <= '0;
              state  <= IDLE;
              if (!rx_s) begin
                frame_err <= 1'b1;
                byte_idx  <= '0;
              end
`ifdef UART_RX_PARITY_EN
              else if (par_bad) begin
                parity_err <= 1'b1;
                byte_idx   <= '0;
              end
`endif
              else begin
                word_buf[{byte_idx, 3'b000} +: 8] <= shreg;
                if (byte_idx == LAST_BYTE) begin
                  byte_idx  <= '0;
                  word_done <= 1'b1;
                end else begin
                  byte_idx <= byte_idx + BIDX_W'(1);
                end
              end
            end else begin
              sample <= sample + SCNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_word.sv
// Randomised bench for uart_rx_word: serial driver, byte-level word model, per-cycle output monitor.
`timescale 1ns/1ps
module tb_uart_rx_word;
  localparam int DW    = 32;
  localparam int OS    = 16;
  localparam int BYTES = DW / 8;
  localparam int BIT_CLKS = OS * 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clken;
  logic          rx = 1'b1;
  logic          ready = 1'b1;
  logic [DW-1:0] data_out;
  logic          valid, frame_err, parity_err, overrun;

  uart_rx_word #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .clken(clken), .rx(rx), .data_out(data_out),
    .valid(valid), .ready(ready), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int ck_div = 0;
  always @(posedge clk) ck_div <= (ck_div + 1) % 4;
  assign clken = (ck_div == 3);

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] part;
  int  part_idx = 0;
  int  exp_frame = 0, exp_par = 0, exp_ovr = 0;
  int  n_frame = 0, n_par = 0, n_ovr = 0, n_words = 0;
  logic [DW-1:0] last_word = '0;
  bit  hold = 1'b0;
  bit  rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, expv);
    end
  endtask

  // Word model: good bytes fill slots LSB-first; a bad frame discards the partial word.
  task automatic model_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    if (bad_stop) begin
      exp_frame++;
      part_idx = 0;
    end else if (bad_par) begin
      exp_par++;
      part_idx = 0;
    end else begin
      part[8*part_idx +: 8] = b;
      part_idx++;
      if (part_idx == BYTES) begin
        part_idx = 0;
        if (hold && exp_q.size() > 0) exp_ovr++;
        else exp_q.push_back(part);
      end
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    model_byte(b, bad_stop, bad_par);
    rx = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ bad_par;
    wait_clk(BIT_CLKS);
`endif
    rx = !bad_stop;
    wait_clk(BIT_CLKS);
    rx = 1'b1;
    if (bad_stop) wait_clk(BIT_CLKS);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = 0; i < BYTES; i++) begin
      send_frame(w[8*i +: 8], 1'b0, 1'b0);
      wait_clk($urandom_range(0, 20));
    end
  endtask

  task automatic set_ready(input bit v);
    ready = v;
    hold  = !v;
  endtask

  initial begin
    bit pv, pr, pf, po, pp;
    logic [DW-1:0] pd;
    logic [DW-1:0] w;
    int base;
    pv = 0; pr = 0; pf = 0; po = 0; pp = 0; pd = '0;

    fork
      forever begin
        @(negedge clk);
        if (rand_ready) ready = ($urandom_range(0, 3) != 0);
        if (rst) begin
          pv = 0; pr = 0; pf = 0; po = 0; pp = 0;
        end else begin
          if (pv && !pr) begin
            chk("hold_valid", 64'(valid), 64'(1));
            chk("hold_data", 64'(data_out), 64'(pd));
          end
          if (pv && pr) chk("valid_fall", 64'(valid), 64'(0));
          if (valid && ready) begin
            if (exp_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL unexpected_word: got %0h want none", data_out);
            end else begin
              w = exp_q.pop_front();
              chk("word", 64'(data_out), 64'(w));
            end
            last_word = data_out;
            n_words++;
          end
          if (frame_err)  begin n_frame++; chk("frame_err_width", 64'(pf), 64'(0)); end
          if (parity_err) begin n_par++;   chk("parity_err_width", 64'(pp), 64'(0)); end
          if (overrun)    begin n_ovr++;   chk("overrun_width", 64'(po), 64'(0)); end
          pv = valid; pr = ready; pd = data_out;
          pf = frame_err; pp = parity_err; po = overrun;
        end
      end
    join_none

    // Reset state
    wait_clk(5);
    @(negedge clk);
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_data", 64'(data_out), 64'(0));
    chk("rst_errs", 64'({frame_err, parity_err, overrun}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clk(BIT_CLKS);

    // Basic word
    set_ready(1'b1);
    send_word(32'h12345678);
    wait_clk(10);
    chk("basic_word", 64'(last_word), 64'h12345678);
    chk("basic_count", 64'(n_words), 64'(1));
    chk("basic_errs", 64'(n_frame + n_ovr + n_par), 64'(0));

    // Start glitch: 5 ticks low is rejected
    base = n_words;
    rx = 1'b0;
    wait_clk(5 * 4);
    rx = 1'b1;
    wait_clk(2 * BIT_CLKS);
    chk("glitch_no_word", 64'(n_words), 64'(base));
    w = $urandom();
    send_word(w);
    wait_clk(10);
    chk("glitch_then_word", 64'(last_word), 64'(w));

    // Frame error drops the partial word
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_word(32'hDDCCBBAA);
    wait_clk(10);
    chk("frame_err_count", 64'(n_frame), 64'(1));
    chk("after_frame_err", 64'(last_word), 64'hDDCCBBAA);

    // Overrun: ready low across two words
    set_ready(1'b0);
    send_word(32'h04030201);
    send_word(32'h08070605);
    wait_clk(10);
    @(negedge clk);
    chk("ovr_valid", 64'(valid), 64'(1));
    chk("ovr_data", 64'(data_out), 64'h04030201);
    chk("ovr_count", 64'(n_ovr), 64'(1));
    @(posedge clk); #1;
    set_ready(1'b1);
    wait_clk(3);
    @(negedge clk);
    chk("ovr_release", 64'(valid), 64'(0));
    chk("ovr_last", 64'(last_word), 64'h04030201);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x01 with parity bit 0 is a mismatch
    send_frame(8'h01, 1'b0, 1'b1);
    w = $urandom();
    send_word(w);
    wait_clk(10);
    chk("parity_count", 64'(n_par), 64'(1));
    chk("parity_then_word", 64'(last_word), 64'(w));
`else
    chk("parity_tied", 64'(n_par), 64'(0));
`endif

    // Reset during byte 3 data bits with a word held
    set_ready(1'b0);
    send_word($urandom());
    for (int i = 0; i < 3; i++) send_frame(8'($urandom()), 1'b0, 1'b0);
    rx = 1'b0;
    wait_clk(BIT_CLKS);
    rx = 1'b1; wait_clk(BIT_CLKS);
    rx = 1'b0; wait_clk(BIT_CLKS);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_valid", 64'(valid), 64'(0));
    chk("midrst_data", 64'(data_out), 64'(0));
    exp_q.delete();
    part_idx = 0;
    rx = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    set_ready(1'b1);
    wait_clk(BIT_CLKS);
    w = $urandom();
    send_word(w);
    wait_clk(10);
    chk("midrst_new_word", 64'(last_word), 64'(w));

    // Random bytes, random consumer, occasional bad stop bits
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_frame(8'($urandom()), ($urandom_range(0, 9) == 0), 1'b0);
      wait_clk($urandom_range(0, 40));
    end
    wait_clk(2 * BIT_CLKS);
    rand_ready = 1'b0;
    ready = 1'b1;
    wait_clk(5);
    chk("rand_drained", 64'(exp_q.size()), 64'(0));
    chk("rand_frame", 64'(n_frame), 64'(exp_frame));
    chk("rand_ovr", 64'(n_ovr), 64'(exp_ovr));
    chk("rand_par", 64'(n_par), 64'(exp_par));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
